// File: rtl/calendar_pkg.sv
// Shared calendar constants: month codes, day bounds and default widths
// used by the date path stages.
package calendar_pkg;

    localparam int DEF_DAY_W    = 5;
    localparam int DEF_MONTH_W  = 4;
    localparam int DEF_FEB_DAYS = 28;

    localparam int DAY_MIN  = 1;
    localparam int DAYS_31  = 31;
    localparam int DAYS_30  = 30;

    localparam logic [DEF_MONTH_W-1:0] JAN = 4'd1;
    localparam logic [DEF_MONTH_W-1:0] FEB = 4'd2;
    localparam logic [DEF_MONTH_W-1:0] MAR = 4'd3;
    localparam logic [DEF_MONTH_W-1:0] APR = 4'd4;
    localparam logic [DEF_MONTH_W-1:0] MAY = 4'd5;
    localparam logic [DEF_MONTH_W-1:0] JUN = 4'd6;
    localparam logic [DEF_MONTH_W-1:0] JUL = 4'd7;
    localparam logic [DEF_MONTH_W-1:0] AUG = 4'd8;
    localparam logic [DEF_MONTH_W-1:0] SEP = 4'd9;
    localparam logic [DEF_MONTH_W-1:0] OCT = 4'd10;
    localparam logic [DEF_MONTH_W-1:0] NOV = 4'd11;
    localparam logic [DEF_MONTH_W-1:0] DEC = 4'd12;

endpackage

// File: rtl/day_counter_if.sv
// Day counter bus: controls from the hour / set-time / month stages in,
// day value, read-back bus and month-advance pulse out.
interface day_counter_if
    import calendar_pkg::*;
#(
    parameter int DAY_W   = DEF_DAY_W,
    parameter int MONTH_W = DEF_MONTH_W
);
    logic               tick;
    logic               load;
    logic [DAY_W-1:0]   data;
    logic               enable;
    logic [MONTH_W-1:0] month;
    logic               leap;
    logic [DAY_W-1:0]   day;
    logic [DAY_W-1:0]   databus;
    logic               month_inc;

    modport master (
        output tick, load, data, enable, month, leap,
        input  day, databus, month_inc
    );

    modport slave (
        input  tick, load, data, enable, month, leap,
        output day, databus, month_inc
    );
endinterface

// File: rtl/month_length.sv
// Combinational month -> number-of-days lookup. February grows by one day
// in leap years only when LEAP_YEAR_EN is defined; otherwise leap is ignored.
// Out-of-range month codes are treated as 31-day months.
module month_length
    import calendar_pkg::*;
#(
    parameter int DAY_W    = DEF_DAY_W,
    parameter int MONTH_W  = DEF_MONTH_W,
    parameter int FEB_DAYS = DEF_FEB_DAYS
) (
    input  logic [MONTH_W-1:0] i_month,
    input  logic               i_leap,
    output logic [DAY_W-1:0]   o_len
);

`ifndef LEAP_YEAR_EN
    // leap has no effect in this build; keep the port for a uniform interface
    logic w_unused_leap;
    assign w_unused_leap = i_leap;
`endif

    // month length lookup
    always_comb begin
        o_len = DAY_W'(DAYS_31);
        case (i_month)
            APR, JUN, SEP, NOV: o_len = DAY_W'(DAYS_30);
            FEB: begin
`ifdef LEAP_YEAR_EN
                o_len = i_leap ? DAY_W'(FEB_DAYS + 1) : DAY_W'(FEB_DAYS);
`else
                o_len = DAY_W'(FEB_DAYS);
`endif
            end
            default: o_len = DAY_W'(DAYS_31);
        endcase
    end

endmodule

// File: rtl/day_counter.sv
// Day-of-month counter feeding the month stage. Advances on the daily tick,
// wraps at the current month length with a one-cycle month_inc pulse, supports
// saturating parallel load and clamps a day left beyond a shortened month.
// Optional leap-year February: define LEAP_YEAR_EN.
module day_counter
    import calendar_pkg::*;
#(
    parameter int DAY_W    = DEF_DAY_W,
    parameter int MONTH_W  = DEF_MONTH_W,
    parameter int FEB_DAYS = DEF_FEB_DAYS
) (
    input  logic           clk,
    input  logic           rst_n,
    day_counter_if.slave   bus
);

    logic [DAY_W-1:0] r_day;
    logic             r_month_inc;
    logic [DAY_W-1:0] w_len;
    logic [DAY_W-1:0] w_load_sat;
    logic [DAY_W-1:0] w_day_nxt;
    logic             w_inc_nxt;

    month_length #(
        .DAY_W    (DAY_W),
        .MONTH_W  (MONTH_W),
        .FEB_DAYS (FEB_DAYS)
    ) u_month_length (
        .i_month (bus.month),
        .i_leap  (bus.leap),
        .o_len   (w_len)
    );

    // load value forced into 1..len
    always_comb begin
        w_load_sat = bus.data;
        if (bus.data == '0)
            w_load_sat = DAY_W'(DAY_MIN);
        else if (bus.data > w_len)
            w_load_sat = w_len;
    end

    // next day / pulse: load > tick > clamp > hold
    always_comb begin
        w_day_nxt = r_day;
        w_inc_nxt = 1'b0;
        if (bus.load) begin
            w_day_nxt = w_load_sat;
        end else if (bus.tick) begin
            if (r_day < w_len) begin
                w_day_nxt = r_day + DAY_W'(1);
            end else begin
                w_day_nxt = DAY_W'(DAY_MIN);
                w_inc_nxt = 1'b1;
            end
        end else if (r_day > w_len) begin
            w_day_nxt = w_len;
        end
    end

    // day and month_inc registers; reset drops any pending pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_day       <= DAY_W'(DAY_MIN);
            r_month_inc <= 1'b0;
        end else begin
            r_day       <= w_day_nxt;
            r_month_inc <= w_inc_nxt;
        end
    end

    assign bus.day       = r_day;
    assign bus.month_inc = r_month_inc;
    assign bus.databus   = r_day & {DAY_W{bus.enable}};

endmodule

// File: tb/tb_day_counter.sv
// Directed bench for day_counter: counting, wrap pulse, load saturation,
// load-over-tick priority, clamp, read-back gating and async reset.
module tb_day_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    day_counter_if dif ();

    day_counter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dif.tick   = 1'b0;
        dif.load   = 1'b0;
        dif.data   = '0;
        dif.enable = 1'b1;
        dif.month  = 4'd1;
        dif.leap   = 1'b0;

        // reset state
        step();
        step();
        chk("rst_day", 32'(dif.day), 1);
        chk("rst_inc", 32'(dif.month_inc), 0);
        chk("rst_bus", 32'(dif.databus), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // January: 30 back-to-back ticks then wrap
        dif.tick = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            chk("jan_day", 32'(dif.day), 32'(i + 1));
            chk("jan_inc", 32'(dif.month_inc), 0);
        end
        step();
        chk("jan_wrap_day", 32'(dif.day), 1);
        chk("jan_wrap_inc", 32'(dif.month_inc), 1);
        dif.tick = 1'b0;
        step();
        chk("jan_inc_1cyc", 32'(dif.month_inc), 0);
        chk("jan_hold_day", 32'(dif.day), 1);

        // April: load 30, tick wraps; load saturation
        dif.month = 4'd4;
        dif.load  = 1'b1;
        dif.data  = 5'd30;
        step();
        dif.load = 1'b0;
        chk("apr_load30", 32'(dif.day), 30);
        dif.tick = 1'b1;
        step();
        dif.tick = 1'b0;
        chk("apr_wrap_day", 32'(dif.day), 1);
        chk("apr_wrap_inc", 32'(dif.month_inc), 1);
        dif.load = 1'b1;
        dif.data = 5'd31;
        step();
        chk("apr_sat_hi", 32'(dif.day), 30);
        chk("apr_sat_inc", 32'(dif.month_inc), 0);
        dif.data = 5'd0;
        step();
        chk("apr_sat_lo", 32'(dif.day), 1);
        dif.load = 1'b0;

        // February with leap flag
        dif.month = 4'd2;
        dif.leap  = 1'b1;
        dif.load  = 1'b1;
        dif.data  = 5'd28;
        step();
        dif.load = 1'b0;
        chk("feb_load28", 32'(dif.day), 28);
        dif.tick = 1'b1;
        step();
`ifdef LEAP_YEAR_EN
        chk("feb_leap_day", 32'(dif.day), 29);
        chk("feb_leap_inc", 32'(dif.month_inc), 0);
        step();
`endif
        dif.tick = 1'b0;
        chk("feb_wrap_day", 32'(dif.day), 1);
        chk("feb_wrap_inc", 32'(dif.month_inc), 1);
        dif.leap = 1'b0;

        // load wins over tick at day 31
        dif.month = 4'd1;
        dif.load  = 1'b1;
        dif.data  = 5'd31;
        step();
        chk("jan_load31", 32'(dif.day), 31);
        dif.data = 5'd15;
        dif.tick = 1'b1;
        step();
        dif.load = 1'b0;
        dif.tick = 1'b0;
        chk("prio_day", 32'(dif.day), 15);
        chk("prio_inc", 32'(dif.month_inc), 0);

        // clamp when month shortens under day 31; read-back gating
        dif.load = 1'b1;
        dif.data = 5'd31;
        step();
        dif.load  = 1'b0;
        dif.month = 4'd6;
        step();
        chk("clamp_day", 32'(dif.day), 30);
        chk("clamp_inc", 32'(dif.month_inc), 0);
        dif.enable = 1'b0;
        #1;
        chk("bus_off", 32'(dif.databus), 0);
        dif.enable = 1'b1;
        #1;
        chk("bus_on", 32'(dif.databus), 30);

        // async reset while month_inc is high
        dif.month = 4'd1;
        dif.load  = 1'b1;
        dif.data  = 5'd31;
        step();
        dif.load = 1'b0;
        dif.tick = 1'b1;
        step();
        dif.tick = 1'b0;
        chk("pre_rst_inc", 32'(dif.month_inc), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_day", 32'(dif.day), 1);
        chk("arst_inc", 32'(dif.month_inc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dif.tick = 1'b1;
        step();
        dif.tick = 1'b0;
        chk("resume_day", 32'(dif.day), 2);
        chk("resume_inc", 32'(dif.month_inc), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
